// File: rtl/divisor_8bits.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per cycle.
// Divide-by-zero skips CALC and reports Q=FF, R=A with div_zero set.
module divisor_8bits (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inicio,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic       ocupado,
    output logic       pronto,
    output logic       div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] rem;
    logic [2:0] cnt;
    logic [8:0] trial;
    logic [8:0] rem_nxt;
    logic [7:0] quo_nxt;
    logic       fits;

    // dvd shifts the dividend out at the top and the quotient in at the bottom
    always_comb begin
        trial   = {rem, dvd[7]};
        fits    = trial >= {1'b0, dvs};
        rem_nxt = fits ? trial - {1'b0, dvs} : trial;
        quo_nxt = {dvd[6:0], fits};
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (inicio) begin
                    state_nxt = (B == 8'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == 3'd7) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd      <= 8'd0;
            dvs      <= 8'd0;
            rem      <= 8'd0;
            cnt      <= 3'd0;
            Q        <= 8'd0;
            R        <= 8'd0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (inicio && B != 8'd0) begin
                        dvd <= A;
                        dvs <= B;
                        rem <= 8'd0;
                        cnt <= 3'd0;
                    end else if (inicio) begin
                        Q        <= 8'hFF;
                        R        <= A;
                        div_zero <= 1'b1;
                    end
                end
                CALC: begin
                    dvd <= quo_nxt;
                    rem <= rem_nxt[7:0];
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        Q        <= quo_nxt;
                        R        <= rem_nxt[7:0];
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ocupado = (state == CALC);
    assign pronto  = (state == DONE);

endmodule
